// File: rtl/m_stage_dm.sv
// M-stage data memory: byte-addressed word array with merged sub-word stores
// and a sign/zero-extended combinational load path feeding the M->W register.

package m_stage_dm_pkg;

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SW  = 6'b101011
  } opcode_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  typedef struct packed {
    logic         load;
    logic         store;
    logic         sext;
    access_size_t size;
  } mem_ctl_t;

  // Anything outside the eight memory opcodes (bubbles included) decodes to
  // neither load nor store, so it can never disturb the array.
  function automatic mem_ctl_t decode_op(input logic [5:0] op);
    mem_ctl_t c;
    c      = '0;
    c.size = SZ_WORD;
    case (op)
      OP_LW:  begin c.load  = 1'b1; c.size = SZ_WORD;                  end
      OP_LH:  begin c.load  = 1'b1; c.size = SZ_HALF; c.sext = 1'b1;  end
      OP_LHU: begin c.load  = 1'b1; c.size = SZ_HALF;                  end
      OP_LB:  begin c.load  = 1'b1; c.size = SZ_BYTE; c.sext = 1'b1;  end
      OP_LBU: begin c.load  = 1'b1; c.size = SZ_BYTE;                  end
      OP_SW:  begin c.store = 1'b1; c.size = SZ_WORD;                  end
      OP_SH:  begin c.store = 1'b1; c.size = SZ_HALF;                  end
      OP_SB:  begin c.store = 1'b1; c.size = SZ_BYTE;                  end
      default: ;
    endcase
    return c;
  endfunction

endpackage

module m_stage_dm
  import m_stage_dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WDataM,
  input  logic [31:0] PCM,
  output logic [31:0] RDM
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  mem_ctl_t              ctl;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic [15:0]           half_lane;
  logic [7:0]            byte_lane;

  // Upper address bits drop out here, which is what makes accesses wrap.
  assign word_idx = ALUOutM[ADDR_WIDTH+1:2];
  assign ctl      = decode_op(InstrM[31:26]);
  assign old_word = mem[word_idx];

  always_comb begin
    merged_word = old_word;
    case (ctl.size)
      SZ_WORD: merged_word = WDataM;
      SZ_HALF: begin
        if (ALUOutM[1]) merged_word[31:16] = WDataM[15:0];
        else            merged_word[15:0]  = WDataM[15:0];
      end
      SZ_BYTE: begin
        case (ALUOutM[1:0])
          2'd0:    merged_word[7:0]   = WDataM[7:0];
          2'd1:    merged_word[15:8]  = WDataM[7:0];
          2'd2:    merged_word[23:16] = WDataM[7:0];
          default: merged_word[31:24] = WDataM[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    half_lane = ALUOutM[1] ? old_word[31:16] : old_word[15:0];
    case (ALUOutM[1:0])
      2'd0:    byte_lane = old_word[7:0];
      2'd1:    byte_lane = old_word[15:8];
      2'd2:    byte_lane = old_word[23:16];
      default: byte_lane = old_word[31:24];
    endcase
  end

  always_comb begin
    RDM = '0;
    if (ctl.load) begin
      case (ctl.size)
        SZ_WORD: RDM = old_word;
        SZ_HALF: RDM = {{16{ctl.sext & half_lane[15]}}, half_lane};
        SZ_BYTE: RDM = {{24{ctl.sext & byte_lane[7]}}, byte_lane};
        default: RDM = '0;
      endcase
    end
  end

  // NOTE: clearing every word on reset rules out a RAM macro; the array is
  // built from resettable flops so reset really leaves it all-zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ctl.store) begin
      mem[word_idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge Clk) begin
    if (!Reset && ctl.store)
      $display("%d@%h: *%h <= %h", $time, PCM, {ALUOutM[31:2], 2'b00}, merged_word);
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{InstrM[25:0], PCM};

endmodule

// File: tb/tb_m_stage_dm.sv
// Scoreboarded bench for m_stage_dm: a byte-array reference model predicts
// each RDM value, a negedge monitor pops and compares.

module tb_m_stage_dm;

  localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LW = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000, SH  = 6'b101001, SW = 6'b101011;
  localparam logic [5:0] NOP = 6'b000000, ADDI = 6'b001000, BEQ = 6'b000100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] InstrM = '0;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WDataM = '0;
  logic [31:0] PCM = '0;
  logic [31:0] RDM;

  m_stage_dm #(.ADDR_WIDTH(12)) dut (
    .Clk(Clk), .Reset(Reset), .InstrM(InstrM), .ALUOutM(ALUOutM),
    .WDataM(WDataM), .PCM(PCM), .RDM(RDM)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          mon_valid = 1'b0;
  logic [7:0]  bmem [16384];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: RDM=%h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain 16 KiB byte array, little-endian.
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
    int a;
    logic [15:0] h;
    logic [7:0]  b;
    a = int'(addr[13:0]);
    case (op)
      LW: begin
        a = a & ~3;
        return {bmem[a+3], bmem[a+2], bmem[a+1], bmem[a]};
      end
      LH, LHU: begin
        a = a & ~1;
        h = {bmem[a+1], bmem[a]};
        return (op == LH) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      LB, LBU: begin
        b = bmem[a];
        return (op == LB) ? {{24{b[7]}}, b} : {24'h0, b};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_store(input logic [5:0] op, input logic [31:0] addr,
                                      input logic [31:0] d);
    int a;
    a = int'(addr[13:0]);
    case (op)
      SW: begin
        a = a & ~3;
        for (int k = 0; k < 4; k++) bmem[a+k] = d[8*k +: 8];
      end
      SH: begin
        a = a & ~1;
        bmem[a] = d[7:0];
        bmem[a+1] = d[15:8];
      end
      SB: bmem[a] = d[7:0];
      default: ;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16384; i++) bmem[i] = 8'h0;
  endfunction

  // One instruction per cycle; the expectation is taken from the model before
  // this cycle's store lands, matching read-old-data behaviour.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rst, input bit chk, input string name);
    @(posedge Clk);
    #1;
    Reset   = rst;
    InstrM  = (op == NOP) ? 32'h0 : {op, 26'($urandom)};
    ALUOutM = addr;
    WDataM  = wdata;
    PCM     = PCM + 32'd4;
    mon_valid = chk;
    if (chk) begin
      exp_q.push_back(model_load(op, addr));
      name_q.push_back(name);
    end
    if (rst) model_clear();
    else     model_store(op, addr, wdata);
  endtask

  always @(negedge Clk) begin
    if (mon_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: RDM=%h expected none", RDM);
      end else begin
        check(name_q.pop_front(), RDM, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [11];
    logic [5:0] op;
    logic [31:0] addr;
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, NOP, ADDI, BEQ};
    model_clear();

    issue(NOP, 32'h0, 32'h0, 1'b1, 1'b0, "reset0");
    issue(NOP, 32'h0, 32'h0, 1'b1, 1'b0, "reset1");
    issue(LW, 32'h0000, 32'h0, 1'b0, 1'b1, "post_reset_lw_0");
    issue(LW, 32'h3FFC, 32'h0, 1'b0, 1'b1, "post_reset_lw_3ffc");

    issue(SW,  32'h10, 32'h12345678, 1'b0, 1'b1, "sw_10");
    issue(LW,  32'h10, 32'h0, 1'b0, 1'b1, "lw_10");
    issue(LBU, 32'h13, 32'h0, 1'b0, 1'b1, "lbu_13");
    issue(LB,  32'h11, 32'h0, 1'b0, 1'b1, "lb_11");
    issue(LHU, 32'h12, 32'h0, 1'b0, 1'b1, "lhu_12");
    issue(LH,  32'h10, 32'h0, 1'b0, 1'b1, "lh_10");

    issue(SW,  32'h20, 32'hFFFF8080, 1'b0, 1'b0, "sw_20");
    issue(LB,  32'h20, 32'h0, 1'b0, 1'b1, "lb_20");
    issue(LBU, 32'h20, 32'h0, 1'b0, 1'b1, "lbu_20");
    issue(LH,  32'h22, 32'h0, 1'b0, 1'b1, "lh_22");
    issue(LHU, 32'h20, 32'h0, 1'b0, 1'b1, "lhu_20");
    issue(LH,  32'h21, 32'h0, 1'b0, 1'b1, "lh_21_bit0_ignored");
    issue(LW,  32'h23, 32'h0, 1'b0, 1'b1, "lw_23_low_bits_ignored");

    issue(SW, 32'h30, 32'h0, 1'b0, 1'b0, "sw_30");
    issue(SH, 32'h32, 32'h0000ABCD, 1'b0, 1'b0, "sh_32");
    issue(SB, 32'h31, 32'h123456EE, 1'b0, 1'b0, "sb_31");
    issue(LW, 32'h30, 32'h0, 1'b0, 1'b1, "lw_30_merged");

    issue(SW, 32'h40, 32'h11111111, 1'b0, 1'b0, "sw_40_a");
    issue(LW, 32'h40, 32'h0, 1'b0, 1'b1, "lw_40_old");
    issue(SW, 32'h40, 32'h22222222, 1'b0, 1'b1, "sw_40_rdm_zero");
    issue(LW, 32'h40, 32'h0, 1'b0, 1'b1, "lw_40_new");
    issue(SW, 32'h4000, 32'h5, 1'b0, 1'b0, "sw_wrap");
    issue(LW, 32'h0, 32'h0, 1'b0, 1'b1, "lw_0_wrap");

    issue(SW, 32'h8, 32'h00000077, 1'b0, 1'b0, "sw_8");
    issue(LW, 32'h8, 32'h0, 1'b0, 1'b1, "lw_8_before_reset");
    issue(SW, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, "sw_8_under_reset");
    issue(LW, 32'h8, 32'h0, 1'b0, 1'b1, "lw_8_after_reset");
    issue(NOP, 32'h8, 32'hFFFFFFFF, 1'b0, 1'b1, "bubble_rdm");
    issue(LW, 32'h8, 32'h0, 1'b0, 1'b1, "lw_8_after_bubble");

    for (int n = 0; n < 400; n++) begin
      op   = ops[$urandom_range(0, 10)];
      addr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 59) == 0)
        issue(op, addr, $urandom, 1'b1, 1'b0, "rand_reset");
      else
        issue(op, addr, $urandom, 1'b0, 1'b1, "rand_op");
    end

    @(posedge Clk);
    #1;
    mon_valid = 1'b0;
    @(negedge Clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
